// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: data/address widths,
// I/O window base, register offsets inside the I/O bank, STAT bit
// positions, and the access-target decode used by the top level.
package cpu_mem_responder_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // I/O window base address; the window is 256 words and only the low
  // four address bits select a register, so upper offsets alias.
  localparam logic [ADDR_W-1:0] IO_BASE_DEF = 16'hFF00;

  localparam logic [3:0] OFF_LED      = 4'd0;
  localparam logic [3:0] OFF_CTRL_LVL = 4'd1;
  localparam logic [3:0] OFF_EDGE     = 4'd2;
  localparam logic [3:0] OFF_TIMER    = 4'd3;
  localparam logic [3:0] OFF_CMP      = 4'd4;
  localparam logic [3:0] OFF_STAT     = 4'd5;

  localparam int STAT_MATCH_BIT = 0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_t;

  // Classify a CPU word address: RAM below ram_depth, I/O at or above
  // io_base, anything in between is unmapped.
  function automatic sel_t decode_addr(input logic [ADDR_W-1:0] a,
                                       input int ram_depth,
                                       input logic [ADDR_W-1:0] io_base);
    sel_t s;
    if (int'(a) < ram_depth) begin
      s = SEL_RAM;
    end else if (a >= io_base) begin
      s = SEL_IO;
    end else begin
      s = SEL_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port word RAM, both ports read-first with registered read data.
// Ports:
//   clk            clock
//   we_A/addr_A/d_A/q_A   port A write enable, address, write data, read data
//   en_B/addr_B/d_B/q_B   port B write enable, address, write data, read data
// Contents are not reset.
module dpram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we_A,
  input  logic [ADDR_W-1:0] addr_A,
  input  logic [DATA_W-1:0] d_A,
  output logic [DATA_W-1:0] q_A,
  input  logic              en_B,
  input  logic [ADDR_W-1:0] addr_B,
  input  logic [DATA_W-1:0] d_B,
  output logic [DATA_W-1:0] q_B
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_A) begin
      mem[addr_A] <= d_A;
    end
    if (en_B) begin
      mem[addr_B] <= d_B;
    end
    q_A <= mem[addr_A];
    q_B <= mem[addr_B];
  end

endmodule

// File: rtl/mmio_regs.sv
// Memory-mapped I/O bank: LED, synchronised controller level, rising-edge
// capture (clear-on-read), free-running timer with prescaler, compare
// register and match status, plus the level interrupt.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   io_sel            current CPU access targets the I/O window
//   offset            register offset (addr[3:0])
//   we, wdata         CPU write strobe and data
//   controller_in     raw asynchronous buttons
//   rdata             registered read data (valid the cycle after the access)
//   led_out           LED register
//   irq               STAT match bit OR any pending edge
module mmio_regs
  import cpu_mem_responder_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_sel,
  input  logic [3:0]        offset,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        controller_in,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] led_out,
  output logic              irq
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]     presc;
  logic              tick;
  logic [4:0]        ctrl_m, ctrl_s, ctrl_q;
  logic [4:0]        rise;
  logic [4:0]        edge_r, edge_nxt;
  logic [DATA_W-1:0] timer_r, timer_inc;
  logic [DATA_W-1:0] cmp_r, led_r;
  logic              stat_r, stat_nxt, stat_set, stat_clr;
  logic              acc_led, acc_edge, acc_cmp, acc_stat;
  logic [DATA_W-1:0] rd_p0;

  always_comb begin
    acc_led   = io_sel && (offset == OFF_LED);
    acc_edge  = io_sel && (offset == OFF_EDGE);
    acc_cmp   = io_sel && (offset == OFF_CMP);
    acc_stat  = io_sel && (offset == OFF_STAT);

    tick      = (presc == PW'(TICK_DIV - 1));
    timer_inc = timer_r + DATA_W'(1);
    rise      = ctrl_s & ~ctrl_q;

    // Every access to EDGE is a read, so the clear-on-read mask (all ones)
    // always covers any write-1-to-clear mask; new edges are ORed in after.
    edge_nxt  = (acc_edge ? 5'b0 : edge_r) | rise;

    stat_set  = tick && (timer_inc == cmp_r);
    stat_clr  = acc_stat && we && wdata[STAT_MATCH_BIT];
    stat_nxt  = stat_set | (stat_r & ~stat_clr);

    rd_p0 = '0;
    if (io_sel) begin
      case (offset)
        OFF_LED:      rd_p0 = we ? wdata : led_r;
        OFF_CTRL_LVL: rd_p0 = {11'b0, ctrl_s};
        OFF_EDGE:     rd_p0 = {11'b0, edge_r};
        OFF_TIMER:    rd_p0 = timer_r;
        OFF_CMP:      rd_p0 = we ? wdata : cmp_r;
        OFF_STAT:     rd_p0 = {15'b0, stat_r};
        default:      rd_p0 = '0;
      endcase
    end
  end

  // Stage p0 -> p1: register state and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      ctrl_m  <= '0;
      ctrl_s  <= '0;
      ctrl_q  <= '0;
      edge_r  <= '0;
      timer_r <= '0;
      cmp_r   <= '0;
      led_r   <= '0;
      stat_r  <= 1'b0;
      rdata   <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      ctrl_m  <= controller_in;
      ctrl_s  <= ctrl_m;
      ctrl_q  <= ctrl_s;
      edge_r  <= edge_nxt;
      if (tick) begin
        timer_r <= timer_inc;
      end
      if (acc_cmp && we) begin
        cmp_r <= wdata;
      end
      if (acc_led && we) begin
        led_r <= wdata;
      end
      stat_r  <= stat_nxt;
      rdata   <= rd_p0;
    end
  end

  assign led_out = led_r;
  assign irq     = stat_r | (|edge_r);

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU external memory port. Decodes each CPU
// access to on-chip RAM, the I/O bank, or unmapped space; serves a
// read-only display port from the same RAM. All reads have one cycle of
// latency.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   write_en        CPU write strobe
//   addr, data_in   CPU word address and write data
//   data_out        CPU read data (one cycle after addr is sampled)
//   addr_B, out_B   display read address and data
//   controller_in   raw controller buttons
//   led_out         LED register
//   irq             level interrupt
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int              RAM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF,
  parameter int              TICK_DIV  = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] addr_B,
  output logic [DATA_W-1:0] out_B,
  input  logic [4:0]        controller_in,
  output logic [DATA_W-1:0] led_out,
  output logic              irq
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  sel_t              sel_p0, sel_p1;
  logic              ram_we_p0;
  logic              byp_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              vld_b_p0, vld_b_p1;
  logic [DATA_W-1:0] ram_q_a, ram_q_b;
  logic [DATA_W-1:0] io_rdata;

  assign sel_p0    = decode_addr(addr, RAM_DEPTH, IO_BASE);
  assign ram_we_p0 = write_en && (sel_p0 == SEL_RAM);
  assign vld_b_p0  = int'(addr_B) < RAM_DEPTH;

  dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .we_A   (ram_we_p0),
    .addr_A (addr[RAM_AW-1:0]),
    .d_A    (data_in),
    .q_A    (ram_q_a),
    .en_B   (1'b0),
    .addr_B (addr_B[RAM_AW-1:0]),
    .d_B    ('0),
    .q_B    (ram_q_b)
  );

  mmio_regs #(
    .TICK_DIV (TICK_DIV)
  ) u_mmio (
    .clk           (clk),
    .reset         (reset),
    .io_sel        (sel_p0 == SEL_IO),
    .offset        (addr[3:0]),
    .we            (write_en),
    .wdata         (data_in),
    .controller_in (controller_in),
    .rdata         (io_rdata),
    .led_out       (led_out),
    .irq           (irq)
  );

  // Stage p0 -> p1: remember what the sampled access targeted. A RAM write
  // always hits the address being read, so the bypass flag is just the
  // RAM write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_p1   <= SEL_NONE;
      byp_p1   <= 1'b0;
      vld_b_p1 <= 1'b0;
    end else begin
      sel_p1   <= sel_p0;
      byp_p1   <= ram_we_p0;
      vld_b_p1 <= vld_b_p0;
    end
  end

  always_ff @(posedge clk) begin
    wdata_p1 <= data_in;
  end

  // Stage p1: final read-data select from registered sources.
  always_comb begin
    data_out = '0;
    case (sel_p1)
      SEL_RAM: data_out = byp_p1 ? wdata_p1 : ram_q_a;
      SEL_IO:  data_out = io_rdata;
      default: data_out = '0;
    endcase
  end

  assign out_B = vld_b_p1 ? ram_q_b : '0;

endmodule
